// File: rtl/counter_pkg.sv
// Shared definitions for the up/down index counters.
package counter_pkg;

    localparam int COUNTER_WIDTH_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cnt_state_t;

endpackage

// File: rtl/countdown_sequencer.sv
// Emits indices MaxNumber..0 on a valid/ready stream, one per accepted beat,
// flags the final beat and pulses Done once the sequence has drained.
module countdown_sequencer
    import counter_pkg::*;
#(
    parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEF
) (
    input  logic                     CLK,
    input  logic                     SYNC_RST,
    input  logic                     LoadValid,
    output logic                     LoadReady,
    input  logic [COUNTER_WIDTH-1:0] MaxNumber,
    input  logic                     Abort,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [COUNTER_WIDTH-1:0] Value,
    output logic                     Last,
    output logic                     Done
);

    cnt_state_t               state, state_n;
    logic [COUNTER_WIDTH-1:0] value_q, value_n;
    logic                     done_q, done_n;

    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            state   <= IDLE;
            value_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            value_q <= value_n;
            done_q  <= done_n;
        end
    end

    // Abort outranks a coincident transfer; the decrement only happens off
    // the final beat, so Value can never wrap below zero.
    always_comb begin
        state_n = state;
        value_n = value_q;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (LoadValid) begin
                    state_n = RUN;
                    value_n = MaxNumber;
                end
            end
            RUN: begin
                if (Abort) begin
                    state_n = IDLE;
                    value_n = '0;
                end else if (OutReady) begin
                    if (value_q == '0) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        value_n = value_q - 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                value_n = '0;
            end
        endcase
    end

    assign LoadReady = (state == IDLE) & ~SYNC_RST;
    assign OutValid  = (state == RUN);
    assign Value     = value_q;
    assign Last      = (state == RUN) & (value_q == '0);
    assign Done      = done_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed plus randomized checks of countdown_sequencer against a queue model.
module tb_countdown_sequencer;

    logic       clk = 1'b0;
    logic       rst, lv, abort, ordy;
    logic [3:0] mx;
    logic       lr, ov, last, done;
    logic [3:0] val;

    int total = 0;
    int bad   = 0;
    int q[$];          // indices still to be emitted, front is presented now
    bit exp_done;
    int acc[$];        // indices observed to transfer

    always #5 clk = ~clk;

    countdown_sequencer #(.COUNTER_WIDTH(4)) dut (
        .CLK(clk), .SYNC_RST(rst), .LoadValid(lv), .LoadReady(lr),
        .MaxNumber(mx), .Abort(abort), .OutValid(ov), .OutReady(ordy),
        .Value(val), .Last(last), .Done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit nd = 0;
        if (rst) begin
            q.delete();
        end else if (q.size() == 0) begin
            if (lv)
                for (int k = int'(mx); k >= 0; k--) q.push_back(k);
        end else if (abort) begin
            q.delete();
        end else if (ordy) begin
            void'(q.pop_front());
            if (q.size() == 0) nd = 1;
        end
        exp_done = rst ? 1'b0 : nd;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            if (ov === 1'b1 && ordy && !abort && !rst) acc.push_back(int'(val));
            @(posedge clk);
            model_edge();
            #1;
            chk("OutValid", ov, q.size() > 0);
            chk("Value", val, (q.size() > 0) ? q[0] : 0);
            chk("Last", last, q.size() == 1);
            chk("Done", done, exp_done);
            chk("LoadReady", lr, (q.size() == 0) && !rst);
            chk("DoneXValid", done & ov, 0);
        end
    endtask

    task automatic load(input logic [3:0] m);
        mx = m; lv = 1'b1;
        cyc(1);
        lv = 1'b0;
    endtask

    initial begin
        rst = 1'b1; lv = 1'b0; abort = 1'b0; ordy = 1'b0; mx = '0;
        q.delete(); exp_done = 0;
        cyc(2);
        rst = 1'b0;
        cyc(1);

        // full countdown from 10 with consumer always ready
        ordy = 1'b1;
        acc.delete();
        load(4'd10);
        cyc(12);
        chk("t1_beats", acc.size(), 11);

        // single-beat sequence
        load(4'd0);
        cyc(3);

        // alternating backpressure: each index accepted exactly once
        acc.delete();
        ordy = 1'b0;
        load(4'd3);
        for (int i = 0; i < 10; i++) begin
            ordy = (i % 2 == 0);
            cyc(1);
        end
        chk("t3_cnt", acc.size(), 4);
        for (int i = 0; i < 4 && i < acc.size(); i++) chk("t3_seq", acc[i], 3 - i);

        // abort while 7 is presented with OutReady high, then reload 2
        ordy = 1'b1;
        load(4'd10);
        cyc(3);
        chk("t4_at7", val, 7);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("t4_lr", lr, 1);
        load(4'd2);
        cyc(4);

        // widest sequence, no wrap past zero
        acc.delete();
        load(4'd15);
        cyc(18);
        chk("t5_cnt", acc.size(), 16);
        if (acc.size() == 16) begin
            chk("t5_first", acc[0], 15);
            chk("t5_final", acc[15], 0);
        end
        chk("t5_nowrap", val, 0);

        // randomized mix of loads, backpressure, aborts and resets
        repeat (400) begin
            lv    = ($urandom_range(0, 3) == 0);
            mx    = 4'($urandom);
            ordy  = ($urandom_range(0, 3) != 0);
            abort = ($urandom_range(0, 25) == 0);
            rst   = ($urandom_range(0, 80) == 0);
            cyc(1);
        end
        lv = 1'b0; abort = 1'b0; rst = 1'b0; ordy = 1'b1;
        cyc(20);

        // load ignored during RUN, then reset mid-sequence
        load(4'd10);
        cyc(5);
        chk("t6_at5", val, 5);
        ordy = 1'b0;
        mx = 4'd3; lv = 1'b1;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        lv = 1'b0; rst = 1'b0;
        cyc(3);
        chk("t6_val", val, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/countdown_sequencer.md
Name: countdown_sequencer

Overview:
Down-counting index source with a valid/ready output stream. It is the mirror of the up-counting Counter: a loop bound is loaded through a load handshake, and the block emits indices from that bound down to 0, one per accepted output transfer. It flags the final index and pulses Done when the sequence completes. It sits between the layer/tile controller and datapath consumers that walk buffers in descending order, such as reverse-order weight fetch and drain of accumulation rows.

Parameters:
COUNTER_WIDTH, 4, width of MaxNumber and Value; the sequence length is MaxNumber+1, from 1 to 2^COUNTER_WIDTH.

Ports:
CLK  input  1  clock, rising edge.
SYNC_RST  input  1  reset, synchronous, active-high.
LoadValid  input  1  a new bound is presented on MaxNumber.
LoadReady  output  1  block can accept a load.
MaxNumber  input  COUNTER_WIDTH  first index emitted; sampled on load transfer.
Abort  input  1  cancel the running sequence.
OutValid  output  1  Value/Last are valid.
OutReady  input  1  consumer accepts the current Value.
Value  output  COUNTER_WIDTH  current index.
Last  output  1  Value is 0, the final beat of the sequence.
Done  output  1  one-cycle pulse after the Last beat transfers.

Behaviour:
- Interface: one clock, CLK. Reset SYNC_RST is synchronous and active-high.
- States: IDLE and RUN.
- Reset:
  - State returns to IDLE.
  - OutValid=0, Value=0, Last=0, Done=0.
  - LoadReady=0 while SYNC_RST is high.
- LoadReady = (state==IDLE) & ~SYNC_RST, combinational from state.
- Load transfer (LoadValid & LoadReady):
  - Next cycle: state RUN, OutValid=1, Value=MaxNumber, Last=(MaxNumber==0).
  - Latency is 1 cycle from load to first beat.
- Out transfer (OutValid & OutReady) with Last=0:
  - Value decrements by 1 next cycle.
  - Last = (Value==1) next cycle.
  - Back-to-back transfers give one index per cycle.
- Out transfer with Last=1:
  - Next cycle: state IDLE, OutValid=0, Value=0, Last=0, Done=1 for exactly one cycle.
  - LoadReady rises in the same cycle as Done.
  - A load in that cycle is accepted normally.
- Stall (OutValid & ~OutReady): Value, Last and OutValid hold stable. OutValid never drops without a transfer, except on Abort or reset.
- Abort in RUN:
  - Takes priority over a coincident out transfer.
  - Next cycle: IDLE, OutValid=0, Value=0, Last=0, no Done.
- Abort in IDLE: ignored; a coincident load is still accepted.
- LoadValid in RUN: ignored (LoadReady=0); MaxNumber is not sampled.
- Width rules:
  - MaxNumber = 2^W-1 gives 2^W beats.
  - Value never wraps below 0; the decrement is only performed when Last=0.
- SYNC_RST mid-sequence: outputs are cleared on the next edge, no Done pulse, and the pending bound is discarded.
- Done and OutValid are never high in the same cycle.

Decomposition:
- counter_pkg holds the state typedef (IDLE, RUN) and the shared COUNTER_WIDTH default constant, reused by Counter.
- No sub-module: one FSM plus one down-counter register fits a single module.

Test Plan:
1. SYNC_RST 2 cycles, then load MaxNumber=10 with OutReady=1 held -> Value 10,9,...,0 on 11 consecutive cycles, Last only with 0, Done high for 1 cycle after, LoadReady=1 in that cycle.
2. Load MaxNumber=0 -> single beat Value=0, Last=1; Done pulses the cycle after transfer.
3. Load MaxNumber=3, OutReady pattern 1,0,1,0,... -> accepted sequence is exactly 3,2,1,0; Value/Last stable during every stall cycle; no skip or duplicate.
4. Load 10; assert Abort in the cycle Value=7 is presented with OutReady=1 -> next cycle OutValid=0 and LoadReady=1, 7 is not counted as transferred, no Done; reload MaxNumber=2 emits 2,1,0 and Done.
5. COUNTER_WIDTH=4, MaxNumber=15 -> 16 beats 15..0, Last on 0; after completion Value=0 with no wrap to 15.
6. Assert SYNC_RST while Value=5 and pulse LoadValid during RUN -> load is ignored during RUN; after reset all outputs are 0 and no Done pulse occurs.
